// File: rtl/gate_selftest_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : gate_selftest_ctrl_if
//  Description : Bundles the start request, the gate-under-test connection
//                and the result signals of the gate self-test sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface gate_selftest_ctrl_if;
    logic       start;
    logic       dut_out;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    // Sequencer side: takes the request and the gate result, drives the rest
    modport master (
        input  start,
        input  dut_out,
        output a,
        output b,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec
    );

    // Requester / gate side
    modport slave (
        output start,
        output dut_out,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec
    );
endinterface
`default_nettype wire

// File: rtl/gate_selftest_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gate_selftest_ctrl
//  Description : Clocked self-test sequencer for one 2-input gate. Steps the
//                gate inputs through 00,01,10,11, holds each vector for
//                SETTLE_CYCLES cycles, samples the gate output and compares
//                it with TRUTH_TABLE. Reports pass, error count and a
//                per-vector failure map.
//  Revision    : 1.0  initial release
// ============================================================================
module gate_selftest_ctrl #(
    parameter logic [3:0]  TRUTH_TABLE   = 4'b0110,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          STOP_ON_FAIL  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    gate_selftest_ctrl_if.master bus
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_CHECK  = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    // Counter terminal value: SETTLE exits after SETTLE_CYCLES cycles
    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err;
    logic [3:0] r_fail;

    logic [1:0] w_state_nxt;
    logic [1:0] w_idx_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_a_nxt;
    logic       w_b_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_pass_nxt;
    logic [2:0] w_err_nxt;
    logic [3:0] w_fail_nxt;

    logic       w_mismatch;
    logic [2:0] w_err_upd;
    logic [1:0] w_idx_inc;

    // Gate output versus the expected truth-table entry for the held vector
    assign w_mismatch = (bus.dut_out != TRUTH_TABLE[r_idx]);
    assign w_err_upd  = r_err + {2'b00, w_mismatch};
    assign w_idx_inc  = r_idx + 2'd1;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= 4'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
            r_fail  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail;

        case (r_state)
            c_ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = c_ST_SETTLE;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = 4'd0;
                    w_a_nxt     = 1'b0;
                    w_b_nxt     = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_pass_nxt  = 1'b0;
                    w_err_nxt   = 3'd0;
                    w_fail_nxt  = 4'd0;
                end
            end

            c_ST_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = c_ST_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end

            c_ST_CHECK: begin
                if (w_mismatch) begin
                    w_fail_nxt[r_idx] = 1'b1;
                    w_err_nxt         = w_err_upd;
                end
                if ((r_idx == 2'd3) || (STOP_ON_FAIL && w_mismatch)) begin
                    w_state_nxt = c_ST_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_err_upd == 3'd0);
                end else begin
                    // Gate inputs move only on the edge that re-enters SETTLE
                    w_state_nxt = c_ST_SETTLE;
                    w_idx_nxt   = w_idx_inc;
                    w_a_nxt     = w_idx_inc[1];
                    w_b_nxt     = w_idx_inc[0];
                    w_cnt_nxt   = 4'd0;
                end
            end

            c_ST_DONE: begin
                // start is deliberately not sampled here; a held start
                // launches the next run from IDLE one cycle later
                w_state_nxt = c_ST_IDLE;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.fail_vec  = r_fail;

endmodule
`default_nettype wire
